// File: rtl/div_iter_if.sv
// Request/result bundle between the ALU and the iterative divider.
interface div_iter_if;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  modport master (
    output signed_div, a, b, start, annul,
    input  result, ready, busy
  );

  modport slave (
    input  signed_div, a, b, start, annul,
    output result, ready, busy
  );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider on operand magnitudes with a final sign fix-up.
// result = {remainder, quotient}; one quotient bit per BUSY cycle.
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | 32 shift/subtract iterations in progress
// DONE  | ready pulse, result valid
module div_iter (
  input  logic clk,
  input  logic rst,
  div_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] mag_b;
  logic [4:0]  cnt;
  logic        q_neg;
  logic        r_neg;
  logic [63:0] result_q;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a_in;
  logic [31:0] mag_b_in;
  logic        b_zero;

  logic [32:0] sh_rem;
  logic        take_sub;
  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] fix_rem;
  logic [31:0] fix_quo;

  assign a_neg    = bus.signed_div & bus.a[31];
  assign b_neg    = bus.signed_div & bus.b[31];
  assign mag_a_in = a_neg ? (~bus.a + 32'd1) : bus.a;
  assign mag_b_in = b_neg ? (~bus.b + 32'd1) : bus.b;
  assign b_zero   = (bus.b == 32'd0);

  // Partial remainder can need 33 bits after the shift, so compare at that width.
  assign sh_rem   = {rem, quo[31]};
  assign take_sub = (sh_rem >= {1'b0, mag_b});
  assign step_rem = take_sub ? (sh_rem[31:0] - mag_b) : sh_rem[31:0];
  assign step_quo = {quo[30:0], take_sub};
  assign fix_rem  = r_neg ? (~step_rem + 32'd1) : step_rem;
  assign fix_quo  = q_neg ? (~step_quo + 32'd1) : step_quo;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = b_zero ? DONE : BUSY;
      end
      BUSY: begin
        if (cnt == 5'd31) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.annul) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= 32'd0;
      quo      <= 32'd0;
      mag_b    <= 32'd0;
      cnt      <= 5'd0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_q <= 64'd0;
    end else if (!bus.annul) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (b_zero) begin
              result_q <= {bus.a, 32'hFFFF_FFFF};
            end else begin
              rem   <= 32'd0;
              quo   <= mag_a_in;
              mag_b <= mag_b_in;
              q_neg <= bus.signed_div & (bus.a[31] ^ bus.b[31]);
              r_neg <= a_neg;
              cnt   <= 5'd0;
            end
          end
        end
        BUSY: begin
          rem <= step_rem;
          quo <= step_quo;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) result_q <= {fix_rem, fix_quo};
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = (state == DONE);
  assign bus.busy   = (state == BUSY);

endmodule
